lcd8080_tx: RTL and testbench
=============================

// Module: lcd8080_tx
// PURPOSE
//  Intel-8080 write-only bus initiator. Drives an 8-bit i8080 LCD/bridge port from a valid/ready command/pixel stream.
//  It is the host-side counterpart of the i8080 capture path. It also serves as a bench driver for the i8080-to-RGB bridge.
//  Runs on the 100 MHz system clock. All bus timing is programmable in CLK cycles.
// PARAMETERS
//  T_SETUP   1  cycles DC/DB stable with nCS low before nWR falls (min 1)
//  T_WRL     3  nWR low width in cycles (min 1)
//  T_WRH     3  nWR high/hold width after rising edge, DB held (min 1)
//  T_CSIDLE  2  min nCS-high cycles after a LAST beat before next accept (min 1)
//  Any parameter set to 0 is treated as 1. Internal counter is 8 bits; values >255 are illegal.
// PORTS
//  CLK       in   1   system clock (100 MHz)
//  RST       in   1   asynchronous, active-high reset
//  IN_VALID  in   1   beat valid
//  IN_READY  out  1   beat accepted when IN_VALID & IN_READY at rising CLK
//  IN_DC     in   1   0 = command, 1 = data; drives LCD_DC
//  IN_WIDE   in   1   1 = send IN_DATA[15:8] then [7:0]; 0 = send IN_DATA[7:0] only
//  IN_DATA   in   16  payload
//  IN_LAST   in   1   release nCS after this beat
//  LCD_nCS   out  1   chip select, active low
//  LCD_DC    out  1   data/command select
//  LCD_nWR   out  1   write strobe; target latches on rising edge
//  LCD_nRD   out  1   constant 1 (no reads)
//  LCD_DB    out  8   data bus
//  BUSY      out  1   state != IDLE
// BEHAVIOUR
//  Clock/reset: one clock, CLK. RST is asynchronous and active-high.
//  Outputs: all LCD_* outputs are registered.
//  Reset values: LCD_nCS=1, LCD_nWR=1, LCD_nRD=1, LCD_DC=1, LCD_DB=0, BUSY=0, state=IDLE.
//  IN_READY: combinational, gated by ~RST.
//  IN_READY=1 in IDLE and in HOLD. It is also 1 in the final WRH cycle of the final byte of a non-LAST beat.
//  Otherwise IN_READY=0.
//  Accept: latch DC, WIDE, DATA and LAST. Select byte = WIDE ? DATA[15:8] : DATA[7:0].
//  Each state loads cnt = param-1 on entry and exits when cnt==0.
//  States:
//   IDLE: nCS=1, nWR=1. On accept -> SETUP.
//   SETUP: nCS=0, DC and DB driven. After T_SETUP cycles -> WRL.
//   WRL: nWR=0. After T_WRL cycles -> WRH.
//   WRH: nWR=1, DB/DC held. After T_WRH cycles, exit as follows:
//    - WIDE and high byte just sent: DB <= DATA[7:0] -> SETUP. nCS stays low.
//    - LAST: nCS=1 -> CSGAP.
//    - else, accept in this cycle: -> SETUP with the new beat. nCS stays low.
//    - else: -> HOLD.
//   HOLD: nCS=0, nWR=1, DB held. On accept -> SETUP.
//   CSGAP: nCS=1. After T_CSIDLE cycles -> IDLE.
//  Cost per byte: T_SETUP+T_WRL+T_WRH cycles (default 7). A wide beat costs 2x.
//  nCS never toggles between the bytes of a wide beat, nor between back-to-back non-LAST beats.
//  DB and DC change only while nWR=1 and at least T_SETUP cycles before nWR falls.
//  IN_* inputs are ignored when not accepted. Upstream changes during a transfer do not affect the bus.
//  Reset mid-transfer: outputs go to reset values immediately (async). The beat in flight is dropped.
//  After RST falls the block is in IDLE and ready.
// TESTING
//  1 Cmd 0x2C (DC=0, WIDE=0, LAST=1), defaults -> nCS low 7 cycles; nWR low cycles 2-4; DB=0x2C; DC=0;
//    then nCS high 2 cycles before IN_READY.
//  2 Pixel 0xF81F (DC=1, WIDE=1, LAST=1) -> two nWR pulses, DB 0xF8 then 0x1F; nCS low continuously for 14 cycles.
//  3 Data 0x11, 0x22, 0x33 with IN_VALID held and LAST on 0x33 -> 3 pulses in 21 cycles; nCS never high;
//    IN_READY pulses once per beat.
//  4 Beat 0xAA (LAST=0), then IN_VALID low for 10 cycles, then 0xBB (LAST=1) -> HOLD with nCS=0, nWR=1, BUSY=1;
//    second pulse carries 0xBB.
//  5 RST pulsed during WRL -> nWR=1, nCS=1, BUSY=0 without waiting for a CLK edge; no further pulses;
//    next beat is sent normally.
//  6 Instance with T_WRL=0, T_SETUP=2 -> nWR low exactly 1 cycle; DB stable 2 cycles before nWR falls.

Source files
------------

// File: rtl/lcd8080_tx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd8080_tx_if : valid/ready beat stream feeding the i8080 write initiator
// Revision      : 1.0
// ----------------------------------------------------------------------------
interface lcd8080_tx_if;
  logic        valid;
  logic        ready;
  logic        dc;
  logic        wide;
  logic [15:0] data;
  logic        last;

  modport master (
    output valid,
    output dc,
    output wide,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  dc,
    input  wide,
    input  data,
    input  last,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/lcd8080_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd8080_tx : Intel-8080 write-only bus initiator, all timing in clk cycles
// Revision   : 1.0
// ----------------------------------------------------------------------------
module lcd8080_tx #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_WRL    = 3,
  parameter int unsigned T_WRH    = 3,
  parameter int unsigned T_CSIDLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  lcd8080_tx_if.slave  s_if,
  output logic         lcd_ncs_o,
  output logic         lcd_dc_o,
  output logic         lcd_nwr_o,
  output logic         lcd_nrd_o,
  output logic [7:0]   lcd_db_o,
  output logic         busy_o
);

  // Zero-valued timings behave as one cycle; counters hold (cycles - 1).
  localparam int unsigned c_setup_eff  = (T_SETUP  == 0) ? 1 : T_SETUP;
  localparam int unsigned c_wrl_eff    = (T_WRL    == 0) ? 1 : T_WRL;
  localparam int unsigned c_wrh_eff    = (T_WRH    == 0) ? 1 : T_WRH;
  localparam int unsigned c_csidle_eff = (T_CSIDLE == 0) ? 1 : T_CSIDLE;
  localparam logic [7:0]  c_setup_ld   = 8'(c_setup_eff  - 1);
  localparam logic [7:0]  c_wrl_ld     = 8'(c_wrl_eff    - 1);
  localparam logic [7:0]  c_wrh_ld     = 8'(c_wrh_eff    - 1);
  localparam logic [7:0]  c_csidle_ld  = 8'(c_csidle_eff - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_WRL   = 3'd2,
    S_WRH   = 3'd3,
    S_HOLD  = 3'd4,
    S_CSGAP = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       ncs_q,   ncs_d;
  logic       nwr_q,   nwr_d;
  logic       dc_q,    dc_d;
  logic [7:0] db_q,    db_d;
  logic [7:0] lo_q,    lo_d;
  logic       hi_q,    hi_d;
  logic       last_q,  last_d;

  logic w_last_slot;
  logic w_ready;
  logic w_accept;
  logic w_load;

  // The final WRH cycle of a non-LAST beat's last byte can chain straight into the next beat.
  assign w_last_slot = (state_q == S_WRH) && (cnt_q == 8'd0) && !hi_q && !last_q;
  assign w_ready     = !rst && ((state_q == S_IDLE) || (state_q == S_HOLD) || w_last_slot);
  assign w_accept    = s_if.valid && w_ready;
  assign s_if.ready  = w_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? (cnt_q - 8'd1) : cnt_q;
    ncs_d   = ncs_q;
    nwr_d   = nwr_q;
    dc_d    = dc_q;
    db_d    = db_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    last_d  = last_q;
    w_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ncs_d  = 1'b1;
        nwr_d  = 1'b1;
        w_load = w_accept;
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_WRL;
          cnt_d   = c_wrl_ld;
          nwr_d   = 1'b0;
        end
      end
      S_WRL: begin
        if (cnt_q == 8'd0) begin
          state_d = S_WRH;
          cnt_d   = c_wrh_ld;
          nwr_d   = 1'b1;
        end
      end
      S_WRH: begin
        if (cnt_q == 8'd0) begin
          if (hi_q) begin
            hi_d    = 1'b0;
            db_d    = lo_q;
            state_d = S_SETUP;
            cnt_d   = c_setup_ld;
          end else if (last_q) begin
            ncs_d   = 1'b1;
            state_d = S_CSGAP;
            cnt_d   = c_csidle_ld;
          end else if (w_accept) begin
            w_load  = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        w_load = w_accept;
      end
      S_CSGAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ncs_d   = 1'b1;
        nwr_d   = 1'b1;
      end
    endcase

    if (w_load) begin
      state_d = S_SETUP;
      cnt_d   = c_setup_ld;
      ncs_d   = 1'b0;
      nwr_d   = 1'b1;
      dc_d    = s_if.dc;
      db_d    = s_if.wide ? s_if.data[15:8] : s_if.data[7:0];
      lo_d    = s_if.data[7:0];
      hi_d    = s_if.wide;
      last_d  = s_if.last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ncs_q   <= 1'b1;
      nwr_q   <= 1'b1;
      dc_q    <= 1'b1;
      db_q    <= 8'd0;
      lo_q    <= 8'd0;
      hi_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ncs_q   <= ncs_d;
      nwr_q   <= nwr_d;
      dc_q    <= dc_d;
      db_q    <= db_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      last_q  <= last_d;
    end
  end

  assign lcd_ncs_o = ncs_q;
  assign lcd_nwr_o = nwr_q;
  assign lcd_dc_o  = dc_q;
  assign lcd_db_o  = db_q;
  assign lcd_nrd_o = 1'b1;
  assign busy_o    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lcd8080_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lcd8080_tx : self-checking bench, bus monitor vs. byte-stream reference
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_lcd8080_tx;
  localparam int TS  = 1;
  localparam int TWL = 3;
  localparam int TWH = 3;
  localparam int TCS = 2;
  localparam int TS6 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd8080_tx_if bus ();
  lcd8080_tx_if bus6 ();

  logic       ncs, dc, nwr, nrd, busy;
  logic [7:0] db;
  logic       ncs6, dc6, nwr6, nrd6, busy6;
  logic [7:0] db6;

  lcd8080_tx #(.T_SETUP(TS), .T_WRL(TWL), .T_WRH(TWH), .T_CSIDLE(TCS)) dut (
    .clk(clk), .rst(rst), .s_if(bus),
    .lcd_ncs_o(ncs), .lcd_dc_o(dc), .lcd_nwr_o(nwr), .lcd_nrd_o(nrd),
    .lcd_db_o(db), .busy_o(busy)
  );

  lcd8080_tx #(.T_SETUP(TS6), .T_WRL(0), .T_WRH(TWH), .T_CSIDLE(TCS)) dut6 (
    .clk(clk), .rst(rst), .s_if(bus6),
    .lcd_ncs_o(ncs6), .lcd_dc_o(dc6), .lcd_nwr_o(nwr6), .lcd_nrd_o(nrd6),
    .lcd_db_o(db6), .busy_o(busy6)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: every accepted beat expands into the {dc, byte} sequence the bus must carry.
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int cs_runs[$];
  int wr_runs[$];
  int setup_seen[$];
  int dbchg_low = 0;
  int rdy_busy  = 0;

  logic       p_nwr = 1'b1, p_ncs = 1'b1, p_dc = 1'b1;
  logic [7:0] p_db = 8'd0;
  int cs_len = 0, wr_len = 0, stab = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_nwr = 1'b1; p_ncs = 1'b1; cs_len = 0; wr_len = 0; stab = 0;
    end else begin
      if (!ncs) cs_len++;
      else if (!p_ncs) begin cs_runs.push_back(cs_len); cs_len = 0; end
      if (ncs) stab = 0;
      else if (db !== p_db || dc !== p_dc) stab = 1;
      else stab++;
      if (!nwr) begin
        if (p_nwr) setup_seen.push_back(stab - 1);
        else if (db !== p_db || dc !== p_dc) dbchg_low++;
        wr_len++;
      end else if (!p_nwr) begin
        wr_runs.push_back(wr_len); wr_len = 0; obs_q.push_back({dc, db});
      end
      if (busy && bus.ready) rdy_busy++;
      p_nwr = nwr; p_ncs = ncs;
    end
    p_db = db; p_dc = dc;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic flush();
    exp_q.delete(); obs_q.delete(); cs_runs.delete(); wr_runs.delete(); setup_seen.delete();
    dbchg_low = 0; rdy_busy = 0;
  endtask

  task automatic drive_beat(input logic dc_i, input logic wide_i, input logic last_i,
                            input logic [15:0] d);
    bit done = 0;
    bus.valid = 1'b1; bus.dc = dc_i; bus.wide = wide_i; bus.last = last_i; bus.data = d;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.ready === 1'b1) begin
        @(posedge clk);
        done = 1;
        if (wide_i) exp_q.push_back({dc_i, d[15:8]});
        exp_q.push_back({dc_i, d[7:0]});
      end
      step();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: beat %h not accepted, ready=%b, expected acceptance", d, bus.ready);
    end
  endtask

  task automatic idle(input int n);
    bus.valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.data = 16'($urandom); bus.dc = 1'($urandom); bus.wide = 1'($urandom); bus.last = 1'($urandom);
      step();
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (busy === 1'b0 && ncs === 1'b1) done = 1;
      else step();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: busy=%b ncs=%b, expected busy=0 ncs=1", busy, ncs);
    end
    step(); step();
  endtask

  task automatic test_reset();
    logic [12:0] o;
    #1 rst = 1'b1;
    #2;
    o = {ncs, nwr, nrd, dc, db, busy};
    n_vec++; if (o !== 13'h1E00) begin n_err++; $display("FAIL reset_outputs: got %h expected %h", o, 13'h1E00); end
    o = {ncs6, nwr6, nrd6, dc6, db6, busy6};
    n_vec++; if (o !== 13'h1E00) begin n_err++; $display("FAIL reset_outputs6: got %h expected %h", o, 13'h1E00); end
    n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL ready_in_reset: got %b expected 0", bus.ready); end
    repeat (3) step();
    rst = 1'b0;
    step();
    n_vec++; if ({bus.ready, busy} !== 2'b10) begin n_err++; $display("FAIL ready_after_reset: got %b expected 10", {bus.ready, busy}); end
  endtask

  task automatic test_cmd();
    logic [12:1] s_ncs, s_nwr, s_rdy, e_ncs, e_nwr, e_rdy;
    bit db_ok = 1;
    flush();
    drive_beat(1'b0, 1'b0, 1'b1, 16'h002C);
    bus.valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      s_ncs[k] = ncs; s_nwr[k] = nwr; s_rdy[k] = bus.ready;
      e_ncs[k] = (k > TS + TWL + TWH);
      e_nwr[k] = !(k > TS && k <= TS + TWL);
      e_rdy[k] = (k > TS + TWL + TWH + TCS);
      if (k <= TS + TWL + TWH && (db !== 8'h2C || dc !== 1'b0)) db_ok = 0;
      step();
    end
    n_vec++; if (s_ncs !== e_ncs) begin n_err++; $display("FAIL cmd_ncs: got %b expected %b", s_ncs, e_ncs); end
    n_vec++; if (s_nwr !== e_nwr) begin n_err++; $display("FAIL cmd_nwr: got %b expected %b", s_nwr, e_nwr); end
    n_vec++; if (s_rdy !== e_rdy) begin n_err++; $display("FAIL cmd_ready: got %b expected %b", s_rdy, e_rdy); end
    n_vec++; if (!db_ok) begin n_err++; $display("FAIL cmd_db_dc: got db/dc not steady, expected 2C/0 throughout"); end
  endtask

  task automatic test_wide();
    flush();
    drive_beat(1'b1, 1'b1, 1'b1, 16'hF81F);
    bus.valid = 1'b0;
    wait_idle();
    n_vec++;
    if (obs_q.size() != 2 || obs_q[0] !== 9'h1F8 || obs_q[1] !== 9'h11F) begin
      n_err++; $display("FAIL wide_bytes: got %0d bytes, expected 1F8,11F", obs_q.size());
    end
    n_vec++;
    if (cs_runs.size() != 1 || cs_runs[0] != 2 * (TS + TWL + TWH)) begin
      n_err++; $display("FAIL wide_ncs_run: got %0d runs, expected one of %0d", cs_runs.size(), 2 * (TS + TWL + TWH));
    end
  endtask

  task automatic test_back_to_back();
    flush();
    drive_beat(1'b1, 1'b0, 1'b0, 16'h0011);
    drive_beat(1'b1, 1'b0, 1'b0, 16'h0022);
    drive_beat(1'b1, 1'b0, 1'b1, 16'h0033);
    bus.valid = 1'b0;
    wait_idle();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++;
    if (cs_runs.size() != 1 || cs_runs[0] != 3 * (TS + TWL + TWH)) begin
      n_err++; $display("FAIL b2b_ncs_run: got %0d runs, expected one of %0d", cs_runs.size(), 3 * (TS + TWL + TWH));
    end
    n_vec++; if (rdy_busy != 2) begin n_err++; $display("FAIL b2b_ready_pulses: got %0d expected 2", rdy_busy); end
  endtask

  task automatic test_hold();
    logic [11:0] o;
    flush();
    drive_beat(1'b1, 1'b0, 1'b0, 16'h00AA);
    idle(10);
    o = {ncs, nwr, busy, bus.ready, db};
    n_vec++; if (o !== {4'b0111, 8'hAA}) begin n_err++; $display("FAIL hold_state: got %h expected %h", o, {4'b0111, 8'hAA}); end
    drive_beat(1'b1, 1'b0, 1'b1, 16'h00BB);
    bus.valid = 1'b0;
    wait_idle();
    n_vec++;
    if (obs_q.size() != 2 || obs_q[0] !== 9'h1AA || obs_q[1] !== 9'h1BB) begin
      n_err++; $display("FAIL hold_bytes: got %0d bytes, expected 1AA,1BB", obs_q.size());
    end
    n_vec++; if (cs_runs.size() != 1) begin n_err++; $display("FAIL hold_ncs_runs: got %0d expected 1", cs_runs.size()); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] o;
    bit seen = 0;
    flush();
    drive_beat(1'b1, 1'b0, 1'b1, 16'h0055);
    bus.valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (nwr === 1'b0) seen = 1; else step();
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rstmid_wrl: got nwr=%b, expected a low strobe", nwr); end
    #2 rst = 1'b1;
    #1;
    o = {ncs, nwr, busy, bus.ready};
    n_vec++; if (o !== 4'b1100) begin n_err++; $display("FAIL rstmid_async: got %b expected 1100", o); end
    repeat (2) step();
    rst = 1'b0;
    flush();
    idle(8);
    n_vec++; if (obs_q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet: got %0d strobes busy=%b, expected 0/0", obs_q.size(), busy); end
    drive_beat(1'b0, 1'b0, 1'b1, 16'h0066);
    bus.valid = 1'b0;
    wait_idle();
    n_vec++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h066) begin
      n_err++; $display("FAIL rstmid_next: got %0d bytes, expected 066", obs_q.size());
    end
  endtask

  task automatic test_timing6();
    logic [12:1] s_nwr, s_ncs, e_nwr, e_ncs;
    bit done = 0, db_ok = 1;
    bus6.valid = 1'b1; bus6.dc = 1'b1; bus6.wide = 1'b0; bus6.last = 1'b1; bus6.data = 16'h12C3;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus6.ready === 1'b1) begin @(posedge clk); done = 1; end
      step();
    end
    bus6.valid = 1'b0;
    n_vec++; if (!done) begin n_err++; $display("FAIL t6_accept: got ready=%b expected acceptance", bus6.ready); end
    for (int k = 1; k <= 12; k++) begin
      s_nwr[k] = nwr6; s_ncs[k] = ncs6;
      e_nwr[k] = !(k == TS6 + 1);
      e_ncs[k] = (k > TS6 + 1 + TWH);
      if (k <= TS6 + 1 + TWH && (db6 !== 8'hC3 || dc6 !== 1'b1 || nrd6 !== 1'b1)) db_ok = 0;
      step();
    end
    n_vec++; if (s_nwr !== e_nwr) begin n_err++; $display("FAIL t6_nwr: got %b expected %b", s_nwr, e_nwr); end
    n_vec++; if (s_ncs !== e_ncs) begin n_err++; $display("FAIL t6_ncs: got %b expected %b", s_ncs, e_ncs); end
    n_vec++; if (!db_ok || busy6 !== 1'b0) begin n_err++; $display("FAIL t6_db: got db=%h busy=%b, expected C3 steady then idle", db6, busy6); end
  endtask

  task automatic test_random();
    int n_last = 0, bad_wr = 0, bad_su = 0;
    logic l;
    flush();
    for (int i = 0; i < 60; i++) begin
      l = ($urandom_range(3) == 0) || (i == 59);
      drive_beat(1'($urandom), 1'($urandom), l, 16'($urandom));
      if (l) n_last++;
      if ($urandom_range(2) != 0) idle($urandom_range(1, 4));
    end
    bus.valid = 1'b0;
    wait_idle();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rnd_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    foreach (wr_runs[i]) if (wr_runs[i] != TWL) bad_wr++;
    foreach (setup_seen[i]) if (setup_seen[i] < TS) bad_su++;
    n_vec++; if (cs_runs.size() != n_last) begin n_err++; $display("FAIL rnd_ncs_runs: got %0d expected %0d", cs_runs.size(), n_last); end
    n_vec++; if (bad_wr != 0) begin n_err++; $display("FAIL rnd_wrl_width: got %0d bad strobes expected 0", bad_wr); end
    n_vec++; if (bad_su != 0) begin n_err++; $display("FAIL rnd_setup: got %0d short setups expected 0", bad_su); end
    n_vec++; if (dbchg_low != 0) begin n_err++; $display("FAIL rnd_db_while_low: got %0d changes expected 0", dbchg_low); end
  endtask

  initial begin
    bus.valid = 1'b0; bus.dc = 1'b0; bus.wide = 1'b0; bus.last = 1'b0; bus.data = 16'h0;
    bus6.valid = 1'b0; bus6.dc = 1'b0; bus6.wide = 1'b0; bus6.last = 1'b0; bus6.data = 16'h0;
    test_reset();
    test_cmd();
    test_wide();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_timing6();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
